// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - access size encodings (opcode[27:26])
//   - FSM state encoding
//   - load/store opcode constants used by the control decoder
//   - req_has_error(): flags illegal size or misaligned address
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Size 2'b10 is illegal; halves must sit on even addresses, words on
  // multiples of four.
  function automatic logic req_has_error(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the datapath request/response signals and the data-memory bus.
//   slave  : seen by the load/store unit (accepts requests, drives memory)
//   master : seen by the environment (datapath + memory model)
// Request : req_valid/req_ready handshake, req_store, req_size, req_extend,
//           req_addr, req_wdata
// Memory  : mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_ack, mem_rdata
// Response: resp_valid, resp_data, resp_err
// ---------------------------------------------------------------------------
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_extend;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, req_store, req_size, req_extend, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_store, req_size, req_extend, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/load_store_unit_lane_steer.sv
// ---------------------------------------------------------------------------
// lane_steer
// Purely combinational big-endian byte-lane logic.
// Inputs : size, offset (addr[1:0]), extend, store_data (right-justified),
//          load_word (raw memory word)
// Outputs: be (bit 3 = lowest byte address), store_lanes (replicated store
//          data), load_data (extracted and sign/zero-extended load value)
// ---------------------------------------------------------------------------
module lane_steer
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        extend,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Big-endian: offset 0 lives in bits 31:24, offset 3 in bits 7:0.
  always_comb begin
    load_byte = 8'h00;
    case (offset)
      2'd0: load_byte = load_word[31:24];
      2'd1: load_byte = load_word[23:16];
      2'd2: load_byte = load_word[15:8];
      2'd3: load_byte = load_word[7:0];
      default: load_byte = 8'h00;
    endcase
    load_half = offset[1] ? load_word[15:0] : load_word[31:16];
  end

  // Stores replicate the datum across every lane so memory only needs the
  // byte enables to pick the right one.
  always_comb begin
    be          = 4'b0000;
    store_lanes = 32'h0;
    load_data   = 32'h0;
    case (size)
      SZ_BYTE: begin
        be          = 4'b1000 >> offset;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{extend & load_byte[7]}}, load_byte};
      end
      SZ_HALF: begin
        be          = offset[1] ? 4'b0011 : 4'b1100;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{extend & load_half[15]}}, load_half};
      end
      SZ_WORD: begin
        be          = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
      end
      default: begin
        be          = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Accepts one load/store per transaction, checks alignment, steers byte
// lanes, handshakes with a variable-latency word memory (with watchdog) and
// returns a one-cycle response.
// Parameters: TIMEOUT (1..65535) - cycles to wait for mem_ack before abort
// Ports     : clk, rst_n (async active-low), bus (load_store_unit_if.slave)
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        extend_q, extend_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] count_q, count_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  steer_size;
  logic [1:0]  steer_off;
  logic        steer_extend;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic [31:0] steer_rdata;

  // One steering instance serves both phases: in IDLE it shapes the
  // incoming request for the memory registers, afterwards it extracts load
  // data using the latched request fields.
  assign steer_size   = (state_q == ST_IDLE) ? bus.req_size       : size_q;
  assign steer_off    = (state_q == ST_IDLE) ? bus.req_addr[1:0]  : off_q;
  assign steer_extend = (state_q == ST_IDLE) ? bus.req_extend     : extend_q;

  lane_steer u_lane_steer (
    .size        (steer_size),
    .offset      (steer_off),
    .extend      (steer_extend),
    .store_data  (bus.req_wdata),
    .load_word   (bus.mem_rdata),
    .be          (steer_be),
    .store_lanes (steer_wdata),
    .load_data   (steer_rdata)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    extend_d     = extend_q;
    off_d        = off_q;
    count_d      = count_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          extend_d = bus.req_extend;
          off_d    = bus.req_addr[1:0];
          if (req_has_error(bus.req_size, bus.req_addr[1:0])) begin
            // Faulting requests never touch memory.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
          end else begin
            state_d     = ST_ACCESS;
            count_d     = 16'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_store;
            mem_be_d    = steer_be;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_d = steer_wdata;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is checked before the watchdog so a last-cycle ack still wins.
        if (bus.mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = mem_we_q ? 32'h0 : steer_rdata;
        end else if (count_q == TIMEOUT_LAST) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = 32'h0;
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        resp_data_d = 32'h0;
        resp_err_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      size_q       <= SZ_BYTE;
      extend_q     <= 1'b0;
      off_q        <= 2'b00;
      count_q      <= 16'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      extend_q     <= extend_d;
      off_q        <= off_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access engine behind the instruction decoder. Accepts one load/store request per transaction from the datapath, driven by the decoder's `mem_wr`, `load_extend` and opcode size bits. Performs alignment checking, big-endian byte-lane steering and load sign/zero extension. Handshakes with a variable-latency word-wide data memory, with a watchdog timeout.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum cycles spent waiting for `mem_ack` before aborting; legal range 1..65535.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: datapath request present.
- `req_ready` output 1: unit can accept a request.
- `req_store` input 1: 1 = store (decoder `mem_wr`), 0 = load.
- `req_size` input 2: opcode[27:26]; 00 byte, 01 half, 11 word, 10 illegal.
- `req_extend` input 1: loads only; 1 = sign-extend, 0 = zero-extend (decoder `load_extend`).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `mem_req` output 1: memory access strobe.
- `mem_we` output 1: write enable.
- `mem_be` output 4: byte enables; bit 3 = bits 31:24 = lowest byte address.
- `mem_addr` output 32: word address; `req_addr` with [1:0] forced to 00.
- `mem_wdata` output 32: lane-steered store data.
- `mem_ack` input 1: access complete; `mem_rdata` valid in the same cycle.
- `mem_rdata` input 32: read word.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_data` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: qualified by `resp_valid`; misaligned, illegal size, or timeout.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch all request fields.
  - If the request is misaligned or has illegal size, go to RESP with error. Misaligned means half with addr[0]=1, or word with addr[1:0]≠00.
  - Otherwise go to ACCESS and clear the timeout counter.
- ACCESS:
  - `mem_req` = 1; `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are held stable from latched registers.
  - Counter increments each cycle without `mem_ack`.
  - On `mem_ack`, capture the response and go to RESP.
  - If the counter reaches `TIMEOUT` without ack, drop `mem_req` and go to RESP with error.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE.
- Byte-lane steering (big-endian, o = addr[1:0]):
  - byte: `be` = 4'b1000 >> o; store data byte replicated to all four lanes.
  - half: `be` = 1100 for o=0, 0011 for o=2; store half replicated to both halves.
  - word: `be` = 1111.
  - Loads drive the same `be` as the equivalent store.
- Load extraction:
  - byte = rdata[31-8o -: 8].
  - half = rdata[31:16] for o=0, rdata[15:0] for o=2.
  - Extend to 32 bits per `req_extend`.
  - Word loads ignore `req_extend`.
- Errors never assert `mem_req`.

## Timing

- Reset values: `req_ready`=1, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0; FSM in IDLE.
- Request accepted on the cycle `req_valid`&&`req_ready`; `mem_req` rises the next cycle.
- Zero-wait memory (ack in the first ACCESS cycle): `resp_valid` appears 2 cycles after acceptance, so throughput is 1 request per 3 cycles.
- `mem_ack` is ignored outside ACCESS.
- Ack on the same cycle the counter hits `TIMEOUT`: the ack wins and there is no error.
- `req_ready` is 0 in ACCESS and RESP. `req_valid` there is ignored; the datapath holds it.
- All outputs are registered except `req_ready`, which decodes the state register.
- `rst_n` asserted mid-transaction: immediate return to reset values. The in-flight access is abandoned and no response is issued.

## Structure

- Shared package holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11.
  - FSM state encodings.
  - Load/store opcode constants already used by the control decoder: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2b.
- One combinational sub-module, `lane_steer`: computes `be`, store-data replication and load extraction/extension from size, offset and extend.
- FSM, timeout counter and output registers live in the top module.

## Test plan

- SB addr 0x103, wdata 0x000000A5, ack after 1 cycle -> `mem_addr`=0x100, `be`=0001, `mem_wdata`=0xA5A5A5A5, `resp_err`=0.
- LB addr 0x101, rdata 0x11F02233, extend=1 -> `resp_data`=0xFFFFFFF0; same request with extend=0 -> 0x000000F0.
- LH addr 0x202, rdata 0xAAAA8001, extend=1 -> `be`=0011, `resp_data`=0xFFFF8001.
- LW addr 0x302 -> no `mem_req` ever, `resp_valid` 1 cycle after acceptance with `resp_err`=1 and `resp_data`=0.
- TIMEOUT=4, no ack -> `mem_req` high exactly 4 cycles, then `resp_err`=1. Repeat with ack in the 4th cycle -> no error.
- Deassert `rst_n` during ACCESS -> all outputs at reset values asynchronously, no `resp_valid`. A request after release completes normally.
